// File: rtl/smi_header_insert_sf.sv
// Prepends a single-flit header word to each SMI frame, shifting the payload up by HeadWidth bytes.
// An overflow flit is appended when the last flit no longer fits after the shift.
module smi_header_insert_sf #(
  parameter int unsigned FlitWidth     = 16,
  parameter int unsigned HeadWidth     = 4,
  parameter int unsigned FifoSize      = 16,
  parameter int unsigned FifoIndexSize = 4,
  parameter int unsigned FlitSplit     = FlitWidth - HeadWidth
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   headerReady,
  input  logic [HeadWidth*8-1:0] headerData,
  output logic                   headerStop,
  input  logic                   smiInReady,
  input  logic [7:0]             smiInEofc,
  input  logic [FlitWidth*8-1:0] smiInData,
  output logic                   smiInStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop
);

  localparam int unsigned DataBits  = FlitWidth * 8;
  localparam int unsigned HeadBits  = HeadWidth * 8;
  localparam int unsigned SplitBits = FlitSplit * 8;
  localparam int unsigned EntryBits = DataBits + 8;
  localparam int unsigned CountBits = FifoIndexSize + 1;
  localparam logic [7:0]  EofcMask  = 8'(2 * FlitWidth - 1);

  typedef enum logic [1:0] {
    InsertIdle      = 2'd0,
    InsertCopyFrame = 2'd1,
    InsertAddTail   = 2'd2
  } state_e;

  // Input register stages
  logic                header_reg_q;
  logic [HeadBits-1:0] header_data_q;
  logic                flit_reg_q;
  logic [DataBits-1:0] flit_data_q;
  logic [7:0]          flit_eofc_q;
  logic                header_halt;
  logic                flit_halt;

  assign headerStop = header_reg_q & header_halt;
  assign smiInStop  = flit_reg_q & flit_halt;

  always_ff @(posedge clk) begin
    if (srst) begin
      header_reg_q <= 1'b0;
      flit_reg_q   <= 1'b0;
    end else begin
      if (!headerStop) header_reg_q <= headerReady;
      if (!smiInStop)  flit_reg_q   <= smiInReady;
    end
  end

  always_ff @(posedge clk) begin
    if (!headerStop) header_data_q <= headerData;
    if (!smiInStop) begin
      flit_data_q <= smiInData;
      flit_eofc_q <= smiInEofc & EofcMask;
    end
  end

  // Insertion state machine
  state_e              state_q, state_d;
  logic [HeadBits-1:0] last_high_q, last_high_d;
  logic [7:0]          last_eofc_q, last_eofc_d;
  logic                fifo_wr;
  logic [DataBits-1:0] wr_data;
  logic [7:0]          wr_eofc;
  logic                fifo_full;
  logic                flit_last;
  logic                flit_spills;
  logic [7:0]          shift_eofc;
  state_e              shift_next;

  // A last flit that spills past FlitSplit leaves its top bytes for an extra tail flit.
  always_comb begin
    flit_last   = (flit_eofc_q != 8'd0);
    flit_spills = (flit_eofc_q > 8'(FlitSplit));
    shift_eofc  = 8'd0;
    shift_next  = InsertCopyFrame;
    if (flit_last) begin
      if (flit_spills) begin
        shift_next = InsertAddTail;
      end else begin
        shift_eofc = flit_eofc_q + 8'(HeadWidth);
        shift_next = InsertIdle;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_high_d = last_high_q;
    last_eofc_d = last_eofc_q;
    fifo_wr     = 1'b0;
    wr_data     = '0;
    wr_eofc     = 8'd0;
    header_halt = 1'b1;
    flit_halt   = 1'b1;
    case (state_q)
      InsertIdle: begin
        if (header_reg_q && flit_reg_q) begin
          fifo_wr = 1'b1;
          wr_data = {flit_data_q[SplitBits-1:0], header_data_q};
          wr_eofc = shift_eofc;
          if (!fifo_full) begin
            header_halt = 1'b0;
            flit_halt   = 1'b0;
            last_high_d = flit_data_q[DataBits-1:SplitBits];
            last_eofc_d = flit_eofc_q;
            state_d     = shift_next;
          end
        end
      end
      InsertCopyFrame: begin
        if (flit_reg_q) begin
          fifo_wr = 1'b1;
          wr_data = {flit_data_q[SplitBits-1:0], last_high_q};
          wr_eofc = shift_eofc;
          if (!fifo_full) begin
            flit_halt   = 1'b0;
            last_high_d = flit_data_q[DataBits-1:SplitBits];
            last_eofc_d = flit_eofc_q;
            state_d     = shift_next;
          end
        end
      end
      InsertAddTail: begin
        fifo_wr = 1'b1;
        wr_data = {{SplitBits{1'b0}}, last_high_q};
        wr_eofc = last_eofc_q - 8'(FlitSplit);
        if (!fifo_full) state_d = InsertIdle;
      end
      default: state_d = InsertIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) state_q <= InsertIdle;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    last_high_q <= last_high_d;
    last_eofc_q <= last_eofc_d;
  end

  // Output FIFO of {eofc, data}
  logic [EntryBits-1:0]     fifo_mem [FifoSize];
  logic [FifoIndexSize-1:0] wr_ptr_q, rd_ptr_q;
  logic [CountBits-1:0]     count_q;
  logic                     push, pop;

  function automatic logic [FifoIndexSize-1:0] ptr_inc(input logic [FifoIndexSize-1:0] p);
    return (p == FifoIndexSize'(FifoSize - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full   = (count_q == CountBits'(FifoSize));
  assign smiOutReady = (count_q != '0);
  assign push        = fifo_wr & ~fifo_full;
  assign pop         = smiOutReady & ~smiOutStop;
  assign {smiOutEofc, smiOutData} = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {wr_eofc, wr_data};
  end

endmodule

// File: tb/tb_smi_header_insert_sf.sv
// Scoreboard bench for smi_header_insert_sf: expected flits come from a byte-stream model
// (header bytes then payload bytes, cut into FlitWidth-byte flits).
module tb_smi_header_insert_sf;

  localparam int unsigned FlitWidth = 16;
  localparam int unsigned HeadWidth = 4;
  localparam logic [31:0] Hdr       = 32'hAABBCCDD;

  typedef struct packed {
    logic [7:0]   eofc;
    logic [7:0]   nvalid;
    logic [127:0] data;
  } exp_t;

  logic         clk;
  logic         srst;
  logic         headerReady;
  logic [31:0]  headerData;
  logic         headerStop;
  logic         smiInReady;
  logic [7:0]   smiInEofc;
  logic [127:0] smiInData;
  logic         smiInStop;
  logic         smiOutReady;
  logic [7:0]   smiOutEofc;
  logic [127:0] smiOutData;
  logic         smiOutStop;

  smi_header_insert_sf #(
    .FlitWidth    (16),
    .HeadWidth    (4),
    .FifoSize     (16),
    .FifoIndexSize(4)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .headerReady(headerReady),
    .headerData (headerData),
    .headerStop (headerStop),
    .smiInReady (smiInReady),
    .smiInEofc  (smiInEofc),
    .smiInData  (smiInData),
    .smiInStop  (smiInStop),
    .smiOutReady(smiOutReady),
    .smiOutEofc (smiOutEofc),
    .smiOutData (smiOutData),
    .smiOutStop (smiOutStop)
  );

  int unsigned  n_chk = 0;
  int unsigned  n_pass = 0;
  int unsigned  cyc = 0;
  int unsigned  hdr_xfer_cyc = 0;
  int unsigned  flit_acc = 0;
  bit           hdr_en = 1'b1;
  bit           flit_en = 1'b1;
  bit           hdr_stop_s = 1'b0;
  bit           flit_stop_s = 1'b0;
  logic [31:0]  hdr_q[$];
  logic [135:0] flit_q[$];
  exp_t         exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Queue a frame for the drivers and, when keep_exp is set, its expected output flits.
  task automatic push_frame(input logic [31:0] hdr, input int nflits, input int last_eofc,
                            input logic [7:0] base, input bit keep_exp);
    logic [7:0]   stream[$];
    logic [127:0] d;
    logic [7:0]   e;
    int           nv;
    int           idx;
    exp_t         x;
    hdr_q.push_back(hdr);
    for (int k = 0; k < HeadWidth; k++) stream.push_back(hdr[8*k+:8]);
    for (int i = 0; i < nflits; i++) begin
      for (int b = 0; b < FlitWidth; b++) d[8*b+:8] = 8'(int'(base) + i * 16 + b);
      e  = (i == nflits - 1) ? 8'(last_eofc) : 8'd0;
      nv = (i == nflits - 1) ? last_eofc : FlitWidth;
      flit_q.push_back({e, d});
      for (int b = 0; b < nv; b++) stream.push_back(d[8*b+:8]);
    end
    idx = 0;
    while (keep_exp && idx < stream.size()) begin
      nv = (stream.size() - idx >= FlitWidth) ? FlitWidth : stream.size() - idx;
      x.data = '0;
      for (int b = 0; b < nv; b++) x.data[8*b+:8] = stream[idx+b];
      x.nvalid = 8'(nv);
      x.eofc   = (idx + FlitWidth >= stream.size()) ? 8'(nv) : 8'd0;
      exp_q.push_back(x);
      idx += nv;
    end
  endtask

  task automatic wait_drain(input bit rnd);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && flit_q.size() == 0 && hdr_q.size() == 0) break;
      @(posedge clk);
      #2;
      smiOutStop = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    smiOutStop = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check_val("drain", 160'(exp_q.size()), 160'd0);
  endtask

  // Header driver
  initial begin
    headerReady = 1'b0;
    headerData  = '0;
    forever begin
      @(negedge clk);
      if (headerReady && !hdr_stop_s && hdr_q.size() > 0) hdr_q.delete(0);
      if (hdr_en && hdr_q.size() > 0) begin
        headerReady = 1'b1;
        headerData  = hdr_q[0];
      end else begin
        headerReady = 1'b0;
      end
      hdr_stop_s = headerStop;
      if (headerReady && !headerStop) hdr_xfer_cyc = cyc;
    end
  end

  // Flit driver
  initial begin
    smiInReady = 1'b0;
    smiInEofc  = '0;
    smiInData  = '0;
    forever begin
      @(negedge clk);
      if (smiInReady && !flit_stop_s && flit_q.size() > 0) begin
        flit_q.delete(0);
        flit_acc++;
      end
      if (flit_en && flit_q.size() > 0) begin
        smiInReady             = 1'b1;
        {smiInEofc, smiInData} = flit_q[0];
      end else begin
        smiInReady = 1'b0;
      end
      flit_stop_s = smiInStop;
    end
  end

  // Output monitor
  initial begin
    exp_t         x;
    logic [127:0] mask;
    forever begin
      @(negedge clk);
      if (smiOutReady && !smiOutStop) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 160'(smiOutReady), 160'd0);
        end else begin
          x = exp_q.pop_front();
          for (int b = 0; b < FlitWidth; b++) mask[8*b+:8] = (b < int'(x.nvalid)) ? 8'hFF : 8'h00;
          check_val("out_eofc", 160'(smiOutEofc), 160'(x.eofc));
          check_val("out_data", 160'(smiOutData & mask), 160'(x.data & mask));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int unsigned acc0;
    bit          seen;
    srst       = 1'b1;
    smiOutStop = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    srst = 1'b0;
    check_val("rst_out_ready", 160'(smiOutReady), 160'd0);
    check_val("rst_in_stop", 160'(smiInStop), 160'd0);
    check_val("rst_hdr_stop", 160'(headerStop), 160'd0);

    push_frame(Hdr, 1, 8, 8'h00, 1'b1);
    wait_drain(1'b0);
    push_frame(Hdr, 1, 16, 8'h00, 1'b1);
    wait_drain(1'b0);
    push_frame(Hdr, 3, 12, 8'h00, 1'b1);
    wait_drain(1'b0);

    // Back-to-back frames: the second header waits in its register.
    push_frame(32'h11223344, 2, 13, 8'h40, 1'b1);
    push_frame(32'h55667788, 1, 3, 8'h80, 1'b1);
    push_frame(32'h99AABBCC, 2, 16, 8'hC0, 1'b1);
    wait_drain(1'b0);

    // Output backpressure: 16 in the FIFO plus one held in the flit register.
    smiOutStop = 1'b1;
    acc0 = flit_acc;
    push_frame(Hdr, 30, 16, 8'h00, 1'b1);
    repeat (40) @(posedge clk);
    #2;
    check_val("bp_accepted", 160'(flit_acc - acc0), 160'd17);
    check_val("bp_in_stop", 160'(smiInStop), 160'd1);
    check_val("bp_out_ready", 160'(smiOutReady), 160'd1);
    smiOutStop = 1'b0;
    wait_drain(1'b0);

    // Header arrives late.
    hdr_en = 1'b0;
    push_frame(Hdr, 1, 8, 8'h00, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    check_val("late_in_stop", 160'(smiInStop), 160'd1);
    check_val("late_no_out", 160'(smiOutReady), 160'd0);
    hdr_en = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = smiOutReady;
    end
    check_val("late_seen", 160'(seen), 160'd1);
    check_val("late_latency", 160'(cyc - hdr_xfer_cyc), 160'd2);
    wait_drain(1'b0);

    // Reset in the middle of a frame.
    smiOutStop = 1'b1;
    acc0 = flit_acc;
    push_frame(Hdr, 5, 16, 8'h00, 1'b0);
    for (int i = 0; i < 50 && flit_acc < acc0 + 2; i++) begin
      @(posedge clk);
      #2;
    end
    check_val("mid_pre_ready", 160'(smiOutReady), 160'd1);
    srst    = 1'b1;
    flit_en = 1'b0;
    @(posedge clk);
    #2;
    srst = 1'b0;
    check_val("mid_rst_ready", 160'(smiOutReady), 160'd0);
    flit_q.delete();
    hdr_q.delete();
    smiOutStop = 1'b0;
    flit_en    = 1'b1;
    push_frame(Hdr, 1, 8, 8'h00, 1'b1);
    wait_drain(1'b0);

    // Random frames with random output stalls.
    for (int f = 0; f < 8; f++) begin
      push_frame($urandom, $urandom_range(1, 4), $urandom_range(1, 16), 8'($urandom), 1'b1);
    end
    wait_drain(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/smi_header_insert_sf.md
# smi_header_insert_sf

Prepends a fixed-size header onto an SMI frame. This is the single-flit-header variant, used when the header is narrower than the flit data width. It is the transmit-side counterpart of the SMI header extractor. It merges one header word per frame with the frame's flits, shifting the payload up by HeadWidth bytes and appending an overflow flit when required. Output goes through a FIFO toward the SMI transmit path.

## Interface
- FlitWidth, 16: flit data width in bytes; a power of two.
- HeadWidth, 4: header width in bytes; strictly less than FlitWidth.
- FifoSize, 16: output FIFO depth; greater than 3.
- FifoIndexSize, 4: FIFO index width; must hold FifoSize-1.
- FlitSplit, FlitWidth-HeadWidth: derived; payload bytes carried in the first output flit.
- clk  in  1  clock.
- srst  in  1  synchronous, active-high reset.
- headerReady  in  1  header word valid.
- headerData  in  HeadWidth*8  header bytes; byte 0 in bits [7:0].
- headerStop  out  1  header backpressure.
- smiInReady  in  1  input flit valid.
- smiInEofc  in  8  end-of-frame control; 0 = not last flit, 1..FlitWidth = valid byte count of the last flit.
- smiInData  in  FlitWidth*8  input flit data; byte 0 in bits [7:0].
- smiInStop  out  1  input flit backpressure.
- smiOutReady  out  1  output flit valid.
- smiOutEofc  out  8  output end-of-frame control, same encoding as smiInEofc.
- smiOutData  out  FlitWidth*8  output flit data.
- smiOutStop  in  1  output backpressure.

## Operation
- Handshake on every link: a transfer occurs on a cycle with Ready=1 and Stop=0.
- Input register stages:
  - Header and flit inputs are each registered: ready is resettable; data/eofc are not.
  - Flit eofc is masked with 2*FlitWidth-1.
  - A stage holds its contents while it is full and halted.
  - smiInStop = flitReg_q & flitHalt.
  - headerStop = headerReg_q & headerHalt.
- Byte mapping: input byte j of a frame becomes output byte j+HeadWidth. Header byte k becomes output byte k.
- State machine (2-bit encoding):
  - **InsertIdle** (reset state):
    - Waits until both the header register and the flit register are full.
    - The output flit is {flit[FlitSplit*8-1:0], header}.
    - On transfer into the FIFO, the header and the flit are consumed together.
    - lastHigh is set to flit[FlitWidth*8-1:FlitSplit*8], and lastEofc to the flit's eofc.
    - Next state is decided by the flit's eofc e:
      - e=0 → InsertCopyFrame.
      - 1 ≤ e ≤ FlitSplit → emit eofc e+HeadWidth; stay in InsertIdle.
      - e > FlitSplit → emit eofc 0; go to InsertAddTail.
    - Neither input is consumed unless both are present.
  - **InsertCopyFrame**:
    - Per input flit, the output flit is {flit[FlitSplit*8-1:0], lastHigh}; lastHigh and lastEofc update on each transfer.
    - The header is halted.
    - Next state is decided by the flit's eofc e:
      - e=0 → stay.
      - 1 ≤ e ≤ FlitSplit → emit e+HeadWidth; go to InsertIdle.
      - e > FlitSplit → emit 0; go to InsertAddTail.
  - **InsertAddTail**:
    - Emits {zeros, lastHigh} with eofc lastEofc-FlitSplit (range 1..HeadWidth).
    - Both inputs are halted.
    - On transfer → InsertIdle.
- The output FIFO stores {eofc, data}, (FlitWidth+1)*8 bits wide. Halts for the state machine come from FIFO-full (buffer stop).
- Bytes at or above the valid count in the final flit are don't-care.
- Eofc values above FlitWidth are illegal input; behaviour is unspecified.

## Timing
- Reset values:
  - smiOutReady=0, smiInStop=0, headerStop=0.
  - FIFO empty, state InsertIdle.
  - Data outputs undefined.
- Reset mid-frame: the partial frame and the FIFO contents are discarded, and the next flit accepted is treated as a frame start.
- Latency:
  - First-flit (empty FIFO, smiOutStop=0): output appears 2 cycles after the later of the header/flit input transfers (1 cycle input register, 1 cycle FIFO).
  - Throughput is one flit per cycle in InsertCopyFrame.
- InsertAddTail costs one extra output cycle, during which smiInStop asserts if a flit is waiting.
- A frame of N flits produces N output flits, or N+1 when the last flit's eofc > FlitSplit.
- Simultaneous FIFO full and a state-machine write: the write is held with no state change. Data is never dropped or duplicated.
- Back-to-back frames: the next frame's header may sit in its register during the current frame. It is consumed only with that frame's first flit.

## Test plan
All scenarios use FlitWidth=16, HeadWidth=4, header 0xAABBCCDD, and input flit bytes 0x00..0x0F.

- **Single short flit**: one flit with eofc 8 → one output flit, eofc 12, bytes 0-3 = DD CC BB AA, bytes 4-11 = 00..07.
- **Single full flit**: one flit with eofc 16 → two output flits:
  - First: eofc 0, bytes 4-15 = 00..0B.
  - Second: eofc 4, bytes 0-3 = 0C..0F.
- **Three-flit frame**: last flit eofc 12 → three output flits with eofc 0, 0, 16. Every input byte j appears at output offset j+4.
- **Output backpressure**: hold smiOutStop=1 for 40 cycles while streaming a 30-flit frame.
  - FIFO fills to 16 entries, then smiInStop asserts.
  - After release, all 30 flits arrive in order with no loss.
- **Header late**: flit presented 5 cycles before the header → no output and smiInStop=1 until the header arrives. The output appears 2 cycles after the header is accepted.
- **Reset mid-frame**: assert srst for 1 cycle after 2 flits of a 5-flit frame.
  - smiOutReady drops the following cycle.
  - A new header + single flit (eofc 8) then yields exactly one flit, eofc 12.
